// File: rtl/ram_slot_arbiter_pkg.sv
`default_nettype none
// -----------------------------------------------------------------------------
// ram_arb_pkg : shared types and constants for the RAM slot arbiter
// Revision    : 1.0
// -----------------------------------------------------------------------------
package ram_arb_pkg;

  typedef enum logic [1:0] {
    SLOT_IDLE = 2'd0,
    SLOT_VIC  = 2'd1,
    SLOT_CPU  = 2'd2,
    SLOT_DMA  = 2'd3
  } slot_t;

  // Half-relative clk on which a granted write strobes ram_we.
  localparam int WE_CNT = 1;

  function automatic int LAST_CNT(input int half_cycles);
    return half_cycles - 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/ram_slot_arbiter_if.sv
`default_nettype none
// -----------------------------------------------------------------------------
// ram_slot_arbiter_if : master ports (VIC/CPU/DMA) and RAM side of the arbiter
// Revision            : 1.0
// -----------------------------------------------------------------------------
interface ram_slot_arbiter_if #(
  parameter int ADDR_WIDTH = 16,
  parameter int DATA_WIDTH = 8
) ();

  logic                  phi0;
  logic [ADDR_WIDTH-1:0] vic_a;
  logic [DATA_WIDTH-1:0] vic_do;
  logic                  aec;
  logic [ADDR_WIDTH-1:0] cpu_a;
  logic                  cpu_we;
  logic [DATA_WIDTH-1:0] cpu_di;
  logic [DATA_WIDTH-1:0] cpu_do;
  logic                  cpu_stall;
  logic                  dma_req;
  logic [ADDR_WIDTH-1:0] dma_a;
  logic                  dma_we;
  logic [DATA_WIDTH-1:0] dma_di;
  logic [DATA_WIDTH-1:0] dma_do;
  logic                  dma_ack;
  logic                  ram_en;
  logic [ADDR_WIDTH-1:0] ram_a;
  logic                  ram_we;
  logic [DATA_WIDTH-1:0] ram_di;
  logic [DATA_WIDTH-1:0] ram_do;

  modport slave (
    output phi0, vic_do, cpu_do, cpu_stall, dma_do, dma_ack,
    output ram_en, ram_a, ram_we, ram_di,
    input  vic_a, aec, cpu_a, cpu_we, cpu_di,
    input  dma_req, dma_a, dma_we, dma_di, ram_do
  );

  modport master (
    input  phi0, vic_do, cpu_do, cpu_stall, dma_do, dma_ack,
    input  ram_en, ram_a, ram_we, ram_di,
    output vic_a, aec, cpu_a, cpu_we, cpu_di,
    output dma_req, dma_a, dma_we, dma_di, ram_do
  );

endinterface
`default_nettype wire

// File: rtl/ram_slot_arbiter_phase_gen.sv
`default_nettype none
// -----------------------------------------------------------------------------
// phase_gen : half-cycle counter and phi0 generator with slot timing strobes
// Revision  : 1.0
// -----------------------------------------------------------------------------
module phase_gen
  import ram_arb_pkg::*;
#(
  parameter int HALF_CYCLES = 4
) (
  input  logic clk,
  input  logic reset,
  output logic phi0,
  output logic slot_start,
  output logic we_slot,
  output logic slot_end
);

  localparam int                 c_cnt_w = (HALF_CYCLES > 1) ? $clog2(HALF_CYCLES) : 1;
  localparam logic [c_cnt_w-1:0] c_last  = c_cnt_w'(LAST_CNT(HALF_CYCLES));
  localparam logic [c_cnt_w-1:0] c_we    = c_cnt_w'(WE_CNT);

  logic [c_cnt_w-1:0] r_cnt;
  logic               r_phi0;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cnt  <= '0;
      r_phi0 <= 1'b0;
    end else if (r_cnt == c_last) begin
      r_cnt  <= '0;
      r_phi0 <= ~r_phi0;
    end else begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign phi0       = r_phi0;
  assign slot_start = (r_cnt == '0);
  assign we_slot    = (r_cnt == c_we);
  assign slot_end   = (r_cnt == c_last);

endmodule
`default_nettype wire

// File: rtl/ram_slot_arbiter.sv
`default_nettype none
// -----------------------------------------------------------------------------
// ram_slot_arbiter : time-multiplexes RAM between VIC-II, CPU and DMA by phi0 half
// Revision         : 1.0
// -----------------------------------------------------------------------------
module ram_slot_arbiter
  import ram_arb_pkg::*;
#(
  parameter int ADDR_WIDTH  = 16,
  parameter int DATA_WIDTH  = 8,
  parameter int HALF_CYCLES = 4
) (
  input  logic               clk,
  input  logic               reset,
  ram_slot_arbiter_if.slave  bus
);

  logic w_phi0;
  logic w_slot_start;
  logic w_we_slot;
  logic w_slot_end;

  phase_gen #(
    .HALF_CYCLES (HALF_CYCLES)
  ) u_phase_gen (
    .clk        (clk),
    .reset      (reset),
    .phi0       (w_phi0),
    .slot_start (w_slot_start),
    .we_slot    (w_we_slot),
    .slot_end   (w_slot_end)
  );

  slot_t                 r_slot;
  logic                  r_slot_wr;
  logic                  r_ram_en;
  logic                  r_ram_we;
  logic [ADDR_WIDTH-1:0] r_ram_a;
  logic [DATA_WIDTH-1:0] r_ram_di;
  logic [DATA_WIDTH-1:0] r_vic_do;
  logic [DATA_WIDTH-1:0] r_cpu_do;
  logic [DATA_WIDTH-1:0] r_dma_do;
  logic                  r_dma_ack;
  logic                  r_cpu_stall;
  slot_t                 w_winner;

  // A VIC steal outranks a pending DMA request; the request simply waits.
  always_comb begin
    w_winner = SLOT_VIC;
    if (w_phi0) begin
      if (!bus.aec) begin
        w_winner = SLOT_VIC;
      end else if (bus.dma_req) begin
        w_winner = SLOT_DMA;
      end else begin
        w_winner = SLOT_CPU;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_slot      <= SLOT_IDLE;
      r_slot_wr   <= 1'b0;
      r_ram_en    <= 1'b0;
      r_ram_we    <= 1'b0;
      r_ram_a     <= '0;
      r_ram_di    <= '0;
      r_vic_do    <= '0;
      r_cpu_do    <= '0;
      r_dma_do    <= '0;
      r_dma_ack   <= 1'b0;
      r_cpu_stall <= 1'b0;
    end else begin
      r_dma_ack <= 1'b0;

      if (w_slot_start) begin
        r_slot      <= w_winner;
        r_ram_en    <= 1'b1;
        r_cpu_stall <= w_phi0 && (w_winner != SLOT_CPU);
        case (w_winner)
          SLOT_CPU: begin
            r_ram_a   <= bus.cpu_a;
            r_ram_di  <= bus.cpu_di;
            r_ram_we  <= bus.cpu_we;
            r_slot_wr <= bus.cpu_we;
          end
          SLOT_DMA: begin
            r_ram_a   <= bus.dma_a;
            r_ram_di  <= bus.dma_di;
            r_ram_we  <= bus.dma_we;
            r_slot_wr <= bus.dma_we;
          end
          default: begin
            r_ram_a   <= bus.vic_a;
            r_ram_di  <= '0;
            r_ram_we  <= 1'b0;
            r_slot_wr <= 1'b0;
          end
        endcase
      end else if (w_we_slot) begin
        r_ram_we <= 1'b0;
      end

      // Sync-read data has settled by the last clk of the half.
      if (w_slot_end) begin
        case (r_slot)
          SLOT_VIC: r_vic_do <= bus.ram_do;
          SLOT_CPU: if (!r_slot_wr) r_cpu_do <= bus.ram_do;
          SLOT_DMA: begin
            if (!r_slot_wr) r_dma_do <= bus.ram_do;
            r_dma_ack <= 1'b1;
          end
          default: ;
        endcase
      end
    end
  end

  assign bus.phi0      = w_phi0;
  assign bus.ram_en    = r_ram_en;
  assign bus.ram_a     = r_ram_a;
  assign bus.ram_we    = r_ram_we;
  assign bus.ram_di    = r_ram_di;
  assign bus.vic_do    = r_vic_do;
  assign bus.cpu_do    = r_cpu_do;
  assign bus.dma_do    = r_dma_do;
  assign bus.dma_ack   = r_dma_ack;
  assign bus.cpu_stall = r_cpu_stall;

endmodule
`default_nettype wire

// File: tb/tb_ram_slot_arbiter.sv
`default_nettype none
// -----------------------------------------------------------------------------
// tb_ram_slot_arbiter : directed self-checking bench with a sync-read RAM model
// Revision            : 1.0
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_ram_slot_arbiter;

  logic clk;
  logic reset;
  int   n_checks;
  int   n_fail;
  int   cyc;
  int   ack_cnt;
  int   ack0;
  logic mem_ready;
  logic [7:0] mem [0:65535];

  ram_slot_arbiter_if #(.ADDR_WIDTH(16), .DATA_WIDTH(8)) bus ();

  ram_slot_arbiter #(
    .ADDR_WIDTH  (16),
    .DATA_WIDTH  (8),
    .HALF_CYCLES (4)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Sync-read RAM, one clk latency; contents seeded on the first clock.
  always @(posedge clk) begin
    if (mem_ready !== 1'b1) begin
      for (int i = 0; i < 65536; i++) mem[i] <= 8'h00;
      mem[16'h0400] <= 8'h20;
      mem[16'h2000] <= 8'h7F;
      mem[16'h1234] <= 8'h55;
      mem_ready     <= 1'b1;
    end else if (bus.ram_en) begin
      if (bus.ram_we) mem[bus.ram_a] <= bus.ram_di;
      bus.ram_do <= mem[bus.ram_a];
    end
  end

  always @(negedge clk) begin
    if (bus.dma_ack === 1'b1) ack_cnt = ack_cnt + 1;
  end

  task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cyc %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
    check_value("phi0", {31'd0, bus.phi0}, (cyc / 4) % 2);
  endtask

  task automatic step_to(input int target);
    while (cyc < target) step();
  endtask

  task automatic check_reset_outs(input string tag);
    check_value({tag, "_ctl"}, {27'd0, bus.phi0, bus.ram_en, bus.ram_we, bus.dma_ack, bus.cpu_stall}, 32'd0);
    check_value({tag, "_ram_a"}, {16'd0, bus.ram_a}, 32'd0);
    check_value({tag, "_ram_di"}, {24'd0, bus.ram_di}, 32'd0);
    check_value({tag, "_do"}, {8'd0, bus.vic_do, bus.cpu_do, bus.dma_do}, 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    n_checks = 0; n_fail = 0; cyc = 0; ack_cnt = 0;
    reset = 1'b1;
    bus.vic_a = 16'h0010; bus.aec = 1'b1;
    bus.cpu_a = 16'h1234; bus.cpu_we = 1'b0; bus.cpu_di = 8'h00;
    bus.dma_req = 1'b0; bus.dma_a = 16'h0000; bus.dma_we = 1'b0; bus.dma_di = 8'h00;

    repeat (3) @(posedge clk);
    #1;
    check_reset_outs("rst");
    @(negedge clk);
    reset = 1'b0;
    cyc = 0;
    check_value("rel_phi0", {31'd0, bus.phi0}, 32'd0);

    // Idle masters: VIC then CPU address on the bus, no writes.
    step();
    check_value("t1_vic_a", {16'd0, bus.ram_a}, 32'h0010);
    check_value("t1_en", {31'd0, bus.ram_en}, 32'd1);
    check_value("t1_we_vic", {31'd0, bus.ram_we}, 32'd0);
    step_to(5);
    check_value("t1_cpu_a", {16'd0, bus.ram_a}, 32'h1234);
    check_value("t1_we_cpu", {31'd0, bus.ram_we}, 32'd0);
    check_value("t1_stall", {31'd0, bus.cpu_stall}, 32'd0);

    // VIC read of 0x0400.
    step_to(8);
    check_value("t2_cpu_rd", {24'd0, bus.cpu_do}, 32'h55);
    check_value("t2_vic_old", {24'd0, bus.vic_do}, 32'h00);
    bus.vic_a = 16'h0400;
    step_to(11);
    check_value("t2_vic_a", {16'd0, bus.ram_a}, 32'h0400);
    check_value("t2_vic_pre", {24'd0, bus.vic_do}, 32'h00);
    step_to(12);
    check_value("t2_vic_do", {24'd0, bus.vic_do}, 32'h20);
    check_value("t2_cpu_hold", {24'd0, bus.cpu_do}, 32'h55);

    // CPU write 0xD5 to 0x1000 then read back.
    bus.cpu_a = 16'h1000; bus.cpu_we = 1'b1; bus.cpu_di = 8'hD5;
    step();
    check_value("t3_we1", {31'd0, bus.ram_we}, 32'd1);
    check_value("t3_a", {16'd0, bus.ram_a}, 32'h1000);
    check_value("t3_di", {24'd0, bus.ram_di}, 32'hD5);
    bus.cpu_we = 1'b0; bus.cpu_di = 8'h00;
    step();
    check_value("t3_we0", {31'd0, bus.ram_we}, 32'd0);
    check_value("t3_di_hold", {24'd0, bus.ram_di}, 32'hD5);
    step_to(16);
    check_value("t3_wr_no_do", {24'd0, bus.cpu_do}, 32'h55);
    step_to(24);
    check_value("t3_rd_back", {24'd0, bus.cpu_do}, 32'hD5);

    // VIC steal with DMA pending, then DMA read of 0x2000.
    bus.aec = 1'b0; bus.dma_req = 1'b1; bus.dma_a = 16'h2000; bus.dma_we = 1'b0;
    ack0 = ack_cnt;
    step_to(29);
    check_value("t4_stall", {31'd0, bus.cpu_stall}, 32'd1);
    check_value("t4_vic_own", {16'd0, bus.ram_a}, 32'h0400);
    step_to(32);
    bus.aec = 1'b1;
    step();
    check_value("t4_no_ack", ack_cnt, ack0);
    step_to(37);
    check_value("t5_stall", {31'd0, bus.cpu_stall}, 32'd1);
    check_value("t5_dma_a", {16'd0, bus.ram_a}, 32'h2000);
    step_to(39);
    check_value("t5_dma_pre", {24'd0, bus.dma_do}, 32'h00);
    step_to(40);
    check_value("t5_ack", {31'd0, bus.dma_ack}, 32'd1);
    check_value("t5_dma_do", {24'd0, bus.dma_do}, 32'h7F);
    check_value("t5_cpu_hold", {24'd0, bus.cpu_do}, 32'hD5);
    bus.dma_we = 1'b1; bus.dma_a = 16'h2001; bus.dma_di = 8'h3C;
    step();
    check_value("t5_ack_pulse", {31'd0, bus.dma_ack}, 32'd0);
    check_value("t5_ack_once", ack_cnt, ack0 + 1);

    // DMA write with request dropped mid-half still completes and acks.
    step_to(45);
    check_value("t5w_we", {31'd0, bus.ram_we}, 32'd1);
    check_value("t5w_a", {16'd0, bus.ram_a}, 32'h2001);
    check_value("t5w_di", {24'd0, bus.ram_di}, 32'h3C);
    bus.dma_req = 1'b0; bus.dma_we = 1'b0;
    step_to(48);
    check_value("t5w_ack", {31'd0, bus.dma_ack}, 32'd1);
    check_value("t5w_do_hold", {24'd0, bus.dma_do}, 32'h7F);
    step();
    check_value("t5w_mem", {24'd0, mem[16'h2001]}, 32'h3C);
    check_value("t5w_ack_cnt", ack_cnt, ack0 + 2);

    // Asynchronous reset in the middle of a CPU write.
    bus.cpu_a = 16'h1001; bus.cpu_we = 1'b1; bus.cpu_di = 8'hAA;
    step_to(53);
    check_value("t6_stall", {31'd0, bus.cpu_stall}, 32'd0);
    check_value("t6_we1", {31'd0, bus.ram_we}, 32'd1);
    #2;
    reset = 1'b1;
    #1;
    check_reset_outs("t6_async");
    bus.cpu_we = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_value("t6_wr_lost", {24'd0, mem[16'h1001]}, 32'h00);
    reset = 1'b0;
    cyc = 0;
    check_value("t6_rel_phi0", {31'd0, bus.phi0}, 32'd0);
    step();
    check_value("t6_vic_first", {16'd0, bus.ram_a}, 32'h0400);
    check_value("t6_we0", {31'd0, bus.ram_we}, 32'd0);
    step_to(4);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
